mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-master arbiter and address decoder for the byte-wide system memory bus.
- Generalises the fixed two-source (CPU / HCI) mux to N_MASTERS requesters with round-robin arbitration, bus lock for multi-byte transfers, and a debug-override master.
- Decodes each access to RAM or the memory-mapped IO window and returns read data one cycle later, tagged to the issuing master.
- Sits between the CPU memory ports / HCI and the ram and hci IO blocks.

Parameters:
N_MASTERS, 3, number of requesting masters (2..8)
DBG_IDX, 2, index of the debug master that pre-empts all others while dbg_active_in=1
RAM_ADDR_WIDTH, 17, RAM address width; IO window is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
LOCK_MAX, 8, maximum consecutive cycles one master may hold the bus via lock

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous active-low reset
dbg_active_in  input  1  debug break active; only DBG_IDX may be granted
req_in  input  N_MASTERS  per-master access request
lock_in  input  N_MASTERS  per-master request to keep the grant next cycle
wr_in  input  N_MASTERS  per-master 1=write, 0=read
addr_in  input  32*N_MASTERS  packed per-master byte addresses, master i at [32i+31:32i]
wdata_in  input  8*N_MASTERS  packed per-master write data
gnt_out  output  N_MASTERS  one-hot grant, combinational, valid in the issue cycle
rvalid_out  output  N_MASTERS  one-hot read-data-valid, registered, one cycle after a granted read
rdata_out  output  8  read data, shared, valid with rvalid_out
stall_out  output  1  registered copy of dbg_active_in, for the CPU ready input
ram_en_out  output  1  RAM chip enable
ram_r_nw_out  output  1  1=read, 0=write
ram_a_out  output  RAM_ADDR_WIDTH  RAM address
ram_d_out  output  8  RAM write data
ram_d_in  input  8  RAM read data, one-cycle synchronous latency
io_en_out  output  1  IO window enable
io_sel_out  output  3  addr[2:0] of the IO access
io_wr_out  output  1  IO write strobe
io_d_out  output  8  IO write data
io_d_in  input  8  IO read data, one-cycle latency

Behaviour:
- Reset (rst_in=0, asynchronous):
  - rr_ptr=0, lock owner cleared, lock counter=0.
  - rvalid_out=0, stall_out=0, and the registered return select cleared.
  - All combinational enables are 0 while in reset.
- Eligibility:
  - dbg_active_in=1: only DBG_IDX is eligible.
  - Otherwise all masters are eligible.
  - Arbitration still runs in the dbg_active_in transition cycle; stall_out lags by one cycle.
- Grant priority:
  1. A valid lock owner that is still requesting and eligible.
  2. Otherwise round-robin: the first requesting, eligible master searching from rr_ptr upward, with wrap-around.
  - No eligible request: gnt_out=0 and ram_en_out=io_en_out=0.
- Issue (same cycle as grant):
  - The granted master's addr, wr and wdata drive the downstream ports.
  - io_en_out=1 iff the IO window decodes; otherwise ram_en_out=1. The two are never both 1.
  - ram_r_nw_out=~wr. io_wr_out=wr & io_en_out.
- Round-robin pointer:
  - On any grant to master g without lock continuation, rr_ptr <= (g+1) mod N_MASTERS.
- Lock:
  - A grant with lock_in[g]=1 makes g the owner for the next cycle, and the lock counter increments.
  - The owner is released when:
    - lock_in[g]=0, or
    - req_in[g]=0, or
    - g becomes ineligible, or
    - the counter reaches LOCK_MAX-1.
  - On LOCK_MAX expiry the next cycle is forced to round-robin with rr_ptr=g+1, even if lock_in is still high.
  - Release clears the counter.
- Read return:
  - A granted read at cycle t asserts rvalid_out[g]=1 at t+1 for exactly one cycle.
  - rdata_out at t+1 is io_d_in if the access was IO, else ram_d_in (registered select).
  - Writes produce no rvalid.
  - Back-to-back reads from different masters return in issue order, one per cycle.
- Simultaneous events:
  - A lock owner losing eligibility in the same cycle a debug break starts loses the grant immediately.
  - Reset mid-transaction discards any pending rvalid.

Test Plan:
- Reset: hold rst_in=0 with all req_in=1 -> gnt_out=0, rvalid_out=0, ram_en_out=io_en_out=0. After release with req_in=3'b111 -> grants 0,1,2,0 on consecutive cycles.
- Decode: master 0 reads addr 0x00001234 -> ram_en_out=1, ram_a_out=0x01234, io_en_out=0. Then master 0 writes 0x00030004, data 0x41 -> io_en_out=1, io_sel_out=3'd4, io_wr_out=1, ram_en_out=0.
- Read return: master 1 reads RAM with ram_d_in=0x5A in the following cycle -> rvalid_out=3'b010 and rdata_out=0x5A exactly one cycle after the grant, then rvalid_out=0.
- Lock: master 0 holds lock_in=1 and req_in=1 while master 1 requests continuously -> master 0 granted exactly LOCK_MAX=8 cycles, then master 1 granted.
- Debug override: req_in=3'b111, dbg_active_in rises -> from that cycle only gnt_out=3'b100; stall_out=1 one cycle later; masters 0 and 1 are never granted until dbg_active_in falls.
- Wrap-around fairness: req_in=3'b101 continuously -> grants alternate 0,2,0,2; master 1 is never granted.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// N-master round-robin arbiter with lock and debug override, plus RAM/IO
// address decode and one-cycle tagged read-data return for the byte-wide bus.
module mem_bus_arbiter #(
    parameter int N_MASTERS      = 3,
    parameter int DBG_IDX        = 2,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int LOCK_MAX       = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      dbg_active_in,
    input  logic [N_MASTERS-1:0]      req_in,
    input  logic [N_MASTERS-1:0]      lock_in,
    input  logic [N_MASTERS-1:0]      wr_in,
    input  logic [32*N_MASTERS-1:0]   addr_in,
    input  logic [8*N_MASTERS-1:0]    wdata_in,
    output logic [N_MASTERS-1:0]      gnt_out,
    output logic [N_MASTERS-1:0]      rvalid_out,
    output logic [7:0]                rdata_out,
    output logic                      stall_out,
    output logic                      ram_en_out,
    output logic                      ram_r_nw_out,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]                ram_d_out,
    input  logic [7:0]                ram_d_in,
    output logic                      io_en_out,
    output logic [2:0]                io_sel_out,
    output logic                      io_wr_out,
    output logic [7:0]                io_d_out,
    input  logic [7:0]                io_d_in
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [31:0] addr_arr  [N_MASTERS];
    logic [7:0]  wdata_arr [N_MASTERS];

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_in[32*gi +: 32];
            assign wdata_arr[gi] = wdata_in[8*gi +: 8];
        end
    endgenerate

    logic [IW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic                 lock_valid_reg, lock_valid_next;
    logic [IW-1:0]        lock_owner_reg, lock_owner_next;
    logic [CW-1:0]        lock_cnt_reg, lock_cnt_next;
    logic [N_MASTERS-1:0] rvalid_reg, rvalid_next;
    logic                 ret_io_reg, ret_io_next;
    logic                 stall_reg;

    logic [N_MASTERS-1:0] elig, cand;
    logic                 owner_hit, gnt_any, sel_wr, is_io, lock_keep;
    logic [IW-1:0]        gnt_idx;
    logic [IW:0]          scan_idx, inc_idx;
    logic [CW-1:0]        cnt_base;
    logic [31:0]          sel_addr;

    always_comb begin
        elig = '1;
        if (dbg_active_in) begin
            elig          = '0;
            elig[DBG_IDX] = 1'b1;
        end
        cand      = req_in & elig;
        owner_hit = lock_valid_reg && cand[lock_owner_reg];
    end

    // A live lock owner wins outright; otherwise scan upward from rr_ptr with wrap.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (rst_in) begin
            if (owner_hit) begin
                gnt_any = 1'b1;
                gnt_idx = lock_owner_reg;
            end else begin
                for (int k = 0; k < N_MASTERS; k++) begin
                    scan_idx = {1'b0, rr_ptr_reg} + (IW+1)'(k);
                    if (scan_idx >= (IW+1)'(N_MASTERS))
                        scan_idx = scan_idx - (IW+1)'(N_MASTERS);
                    if (!gnt_any && cand[scan_idx[IW-1:0]]) begin
                        gnt_any = 1'b1;
                        gnt_idx = scan_idx[IW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        sel_addr = addr_arr[gnt_idx];
        sel_wr   = wr_in[gnt_idx];
        is_io    = (sel_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);

        gnt_out = '0;
        if (gnt_any)
            gnt_out[gnt_idx] = 1'b1;

        ram_en_out   = gnt_any && !is_io;
        io_en_out    = gnt_any && is_io;
        ram_r_nw_out = ~sel_wr;
        ram_a_out    = sel_addr[RAM_ADDR_WIDTH-1:0];
        ram_d_out    = wdata_arr[gnt_idx];
        io_sel_out   = sel_addr[2:0];
        io_wr_out    = sel_wr && io_en_out;
        io_d_out     = wdata_arr[gnt_idx];
    end

    // Lock count restarts on a fresh grant; reaching LOCK_MAX-1 forces release.
    always_comb begin
        cnt_base        = owner_hit ? lock_cnt_reg : '0;
        lock_keep       = gnt_any && lock_in[gnt_idx] && (cnt_base != CW'(LOCK_MAX - 1));
        lock_valid_next = lock_keep;
        lock_owner_next = lock_keep ? gnt_idx : '0;
        lock_cnt_next   = lock_keep ? cnt_base + CW'(1) : '0;

        inc_idx = {1'b0, gnt_idx} + (IW+1)'(1);
        if (inc_idx >= (IW+1)'(N_MASTERS))
            inc_idx = '0;
        rr_ptr_next = gnt_any ? inc_idx[IW-1:0] : rr_ptr_reg;

        rvalid_next = (gnt_any && !sel_wr) ? gnt_out : '0;
        ret_io_next = is_io;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_reg     <= '0;
            lock_valid_reg <= 1'b0;
            lock_owner_reg <= '0;
            lock_cnt_reg   <= '0;
            rvalid_reg     <= '0;
            ret_io_reg     <= 1'b0;
            stall_reg      <= 1'b0;
        end else begin
            rr_ptr_reg     <= rr_ptr_next;
            lock_valid_reg <= lock_valid_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            rvalid_reg     <= rvalid_next;
            ret_io_reg     <= ret_io_next;
            stall_reg      <= dbg_active_in;
        end
    end

    assign rvalid_out = rvalid_reg;
    assign stall_out  = stall_reg;
    assign rdata_out  = ret_io_reg ? io_d_in : ram_d_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed vectors push expected issue
// and read-return records; negedge monitors pop and compare.
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        dbg_active_in;
    logic [2:0]  req_in, lock_in, wr_in;
    logic [95:0] addr_in;
    logic [23:0] wdata_in;
    logic [2:0]  gnt_out, rvalid_out;
    logic [7:0]  rdata_out;
    logic        stall_out;
    logic        ram_en_out, ram_r_nw_out;
    logic [16:0] ram_a_out;
    logic [7:0]  ram_d_out, ram_d_in;
    logic        io_en_out;
    logic [2:0]  io_sel_out;
    logic        io_wr_out;
    logic [7:0]  io_d_out, io_d_in;

    mem_bus_arbiter #(
        .N_MASTERS(3), .DBG_IDX(2), .RAM_ADDR_WIDTH(17), .LOCK_MAX(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .dbg_active_in(dbg_active_in),
        .req_in(req_in), .lock_in(lock_in), .wr_in(wr_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt_out(gnt_out), .rvalid_out(rvalid_out), .rdata_out(rdata_out),
        .stall_out(stall_out),
        .ram_en_out(ram_en_out), .ram_r_nw_out(ram_r_nw_out),
        .ram_a_out(ram_a_out), .ram_d_out(ram_d_out), .ram_d_in(ram_d_in),
        .io_en_out(io_en_out), .io_sel_out(io_sel_out), .io_wr_out(io_wr_out),
        .io_d_out(io_d_out), .io_d_in(io_d_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  gnt;
        logic        ram_en, io_en, r_nw, io_wr, stall, wr;
        logic [16:0] ram_a;
        logic [2:0]  io_sel;
        logic [7:0]  d;
    } iss_t;

    typedef struct {
        int         cyc;
        logic [2:0] rv;
        logic [7:0] rd;
    } rd_t;

    iss_t iq[$];
    rd_t  rdq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic stall_m = 1'b0;

    localparam logic [31:0] A0 = 32'h0000_1234;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] A2 = 32'h0003_0001;

    function automatic logic [7:0] rd_of(input int n);
        return 8'(n * 37 + 5);
    endfunction

    function automatic logic [7:0] io_of(input int n);
        return 8'(n * 53 + 11);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One bus cycle: apply inputs, record expectations, advance past the edge.
    task automatic drive(input logic rst, input logic dbg, input logic [2:0] req,
                         input logic [2:0] lock, input logic [2:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [23:0] wd,
                         input logic [2:0] exp_gnt);
        iss_t        e;
        rd_t         r;
        int          g;
        logic [31:0] a;
        logic        io;
        rst_in        = rst;
        dbg_active_in = dbg;
        req_in        = req;
        lock_in       = lock;
        wr_in         = wr;
        addr_in       = {a2, a1, a0};
        wdata_in      = wd;
        ram_d_in      = rd_of(cyc);
        io_d_in       = io_of(cyc);
        if (!rst && rdq.size() > 0 && rdq[$].cyc == cyc)
            void'(rdq.pop_back());
        g  = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
        a  = (g == 0) ? a0 : ((g == 1) ? a1 : a2);
        io = (a[17:16] == 2'b11);
        e.gnt    = exp_gnt;
        e.ram_en = (exp_gnt != 3'b000) && !io;
        e.io_en  = (exp_gnt != 3'b000) && io;
        e.wr     = wr[g];
        e.r_nw   = !wr[g];
        e.io_wr  = e.io_en && wr[g];
        e.stall  = rst ? stall_m : 1'b0;
        e.ram_a  = a[16:0];
        e.io_sel = a[2:0];
        e.d      = wd[8*g +: 8];
        iq.push_back(e);
        if (exp_gnt != 3'b000 && !wr[g]) begin
            r.cyc = cyc + 1;
            r.rv  = exp_gnt;
            r.rd  = io ? io_of(cyc + 1) : rd_of(cyc + 1);
            rdq.push_back(r);
        end
        stall_m = rst ? dbg : 1'b0;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    always @(negedge clk_in) begin
        iss_t e;
        if (iq.size() > 0) begin
            e = iq.pop_front();
            chk("gnt", 32'(gnt_out), 32'(e.gnt));
            chk("ram_en", 32'(ram_en_out), 32'(e.ram_en));
            chk("io_en", 32'(io_en_out), 32'(e.io_en));
            chk("stall", 32'(stall_out), 32'(e.stall));
            if (e.ram_en) begin
                chk("ram_a", 32'(ram_a_out), 32'(e.ram_a));
                chk("ram_r_nw", 32'(ram_r_nw_out), 32'(e.r_nw));
                if (e.wr) chk("ram_d", 32'(ram_d_out), 32'(e.d));
            end
            if (e.io_en) begin
                chk("io_sel", 32'(io_sel_out), 32'(e.io_sel));
                chk("io_wr", 32'(io_wr_out), 32'(e.io_wr));
                if (e.wr) chk("io_d", 32'(io_d_out), 32'(e.d));
            end
        end
    end

    always @(negedge clk_in) begin
        rd_t r;
        if (rvalid_out !== 3'b000) begin
            if (rdq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rvalid_unexpected @cyc %0d: got %b expected 000", cyc, rvalid_out);
            end else begin
                r = rdq.pop_front();
                chk("rvalid_cyc", 32'(cyc), 32'(r.cyc));
                chk("rvalid", 32'(rvalid_out), 32'(r.rv));
                chk("rdata", 32'(rdata_out), 32'(r.rd));
            end
        end
    end

    initial begin
        rst_in = 1'b0; dbg_active_in = 1'b0;
        req_in = '0; lock_in = '0; wr_in = '0;
        addr_in = '0; wdata_in = '0; ram_d_in = '0; io_d_in = '0;
        @(posedge clk_in);
        #1;

        // Reset holds everything off even with all masters requesting.
        repeat (2) drive(0, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b000);

        // Round-robin after release; master 2 reads from the IO window.
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b010);
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b100);
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);

        // Decode: RAM read then IO write.
        drive(1, 0, 3'b001, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        drive(1, 0, 3'b001, 3'b000, 3'b001, 32'h0003_0004, A1, A2, 24'h000041, 3'b001);

        // Single read return from master 1, then idle.
        drive(1, 0, 3'b010, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b010);
        drive(1, 0, 3'b000, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b000);

        // Lock: master 0 holds for LOCK_MAX cycles, then master 1 gets in.
        repeat (8) drive(1, 0, 3'b011, 3'b001, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        drive(1, 0, 3'b011, 3'b001, 3'b000, A0, A1, A2, 24'h0, 3'b010);

        // Debug override and stall lag.
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b100);
        repeat (3) drive(1, 1, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b100);
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        drive(1, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b010);

        // Lock owner loses the bus the moment a debug break starts.
        drive(1, 0, 3'b011, 3'b001, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        drive(1, 1, 3'b111, 3'b001, 3'b000, A0, A1, A2, 24'h0, 3'b100);
        drive(1, 0, 3'b011, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);

        // Wrap-around fairness with masters 0 and 2.
        repeat (3) begin
            drive(1, 0, 3'b101, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b100);
            drive(1, 0, 3'b101, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b001);
        end

        // Reset right after a read discards its return; pointer restarts at 0.
        drive(1, 0, 3'b010, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b010);
        drive(0, 0, 3'b111, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b000);
        drive(1, 0, 3'b100, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b100);
        repeat (2) drive(1, 0, 3'b000, 3'b000, 3'b000, A0, A1, A2, 24'h0, 3'b000);

        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        chk("iq_drained", 32'(iq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
